// File: rtl/muldiv_sequencer_if.sv
// Handshake and data bundle between the control unit and the MUL/DIV sequencer.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic             set_flags;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags_out;
  logic [1:0]       flag_w;

  modport master (
    output start, op, set_flags, src_a, src_b,
    input  stall, done, result, flags_out, flag_w
  );

  modport slave (
    input  start, op, set_flags, src_a, src_b,
    output stall, done, result, flags_out, flag_w
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned shift-add multiplier / restoring divider that stalls the
// pipeline for WIDTH cycles and reports result, NZCV flags and flag enables.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  muldiv_sequencer_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             s_q, s_d;
  // a: multiplicand / dividend, b: multiplier / divisor, acc: product / quotient
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] step_a, step_b, step_acc, step_rem;

  // One iteration of the selected algorithm, computed from the current state.
  // The shifted remainder keeps one extra bit so divisors above 2^(WIDTH-1)
  // still compare correctly; after subtraction it always fits in WIDTH bits.
  always_comb begin
    rem_sh   = {rem_q, a_q[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, b_q});
    step_a   = a_q << 1;
    step_b   = b_q;
    step_acc = acc_q;
    step_rem = rem_q;
    if (op_q) begin
      step_rem = rem_ge ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0];
      step_acc = {acc_q[WIDTH-2:0], rem_ge};
    end else begin
      step_acc = b_q[0] ? (acc_q + a_q) : acc_q;
      step_b   = b_q >> 1;
    end
  end

  // Next-state and datapath update for the IDLE/CALC/DONE sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    s_d      = s_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    result_d = result_q;
    flags_d  = flags_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d  = bus.op;
          s_d   = bus.set_flags;
          a_d   = bus.src_a;
          b_d   = bus.src_b;
          acc_d = '0;
          rem_d = '0;
          cnt_d = '0;
          if (bus.op && (bus.src_b == '0)) begin
            result_d = '1;
            flags_d  = 4'b1001;
            state_d  = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        a_d   = step_a;
        b_d   = step_b;
        acc_d = step_acc;
        rem_d = step_rem;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d = step_acc;
          flags_d  = {step_acc[WIDTH-1], (step_acc == '0), 2'b00};
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      s_q      <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      s_q      <= s_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  // Output decode; reset overrides a same-cycle start so no stall is raised.
  always_comb begin
    bus.stall     = !rst && (((state_q == IDLE) && bus.start) || (state_q == CALC));
    bus.done      = (state_q == DONE);
    bus.flag_w    = ((state_q == DONE) && s_q) ? 2'b11 : 2'b00;
    bus.result    = result_q;
    bus.flags_out = flags_q;
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table plus scoreboard queue,
// with hand-written sequences for reset abort, ignored start and rst/start clash.
module tb_muldiv_sequencer;
  localparam int W = 32;

  typedef struct {
    logic        op;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
    logic [1:0]  fw;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  muldiv_sequencer_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[9];
  vec_t sb_q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic op, input logic s, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] res,
                              input logic [3:0] flg, input logic [1:0] fw, input int lat);
    vec_t v;
    v.op = op; v.s = s; v.a = a; v.b = b;
    v.res = res; v.flg = flg; v.fw = fw; v.lat = lat;
    return v;
  endfunction

  // Count done pulses over n cycles; none are expected.
  task automatic quiet(input string name, input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check(name, pulses, 0);
  endtask

  // Issue one operation, follow it to done and compare against the scoreboard.
  // poke > 0 re-asserts start with new operands in that CALC cycle.
  task automatic run_op(input vec_t v, input int poke);
    int   cyc;
    logic stall_bad;
    vec_t e;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.op        = v.op;
    bus.set_flags = v.s;
    bus.src_a     = v.a;
    bus.src_b     = v.b;
    sb_q.push_back(v);
    #1 check("stall_accept", bus.stall, 1);
    @(negedge clk);
    bus.start     = 1'b0;
    bus.op        = ~v.op;
    bus.set_flags = ~v.s;
    bus.src_a     = $urandom;
    bus.src_b     = $urandom;
    cyc       = 1;
    stall_bad = 1'b0;
    while (!bus.done && cyc < 100) begin
      if (!bus.stall) stall_bad = 1'b1;
      if (cyc == poke) begin
        bus.start = 1'b1;
        bus.src_a = 32'd999;
        bus.src_b = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check("latency", cyc, v.lat);
    check("stall_window", stall_bad, 0);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue, expected pending entry");
    end else begin
      e = sb_q.pop_front();
      if (bus.done) begin
        check("stall_in_done", bus.stall, 0);
        check("result", bus.result, e.res);
        check("flags_out", bus.flags_out, e.flg);
        check("flag_w", bus.flag_w, e.fw);
      end
    end
    @(negedge clk);
    check("done_pulse_width", bus.done, 0);
    check("result_hold", bus.result, v.res);
    check("flag_w_idle", bus.flag_w, 0);
  endtask

  initial begin
    vecs[0] = mk(1'b0, 1'b1, 32'd7,        32'd6,        32'd42,       4'b0000, 2'b11, 33);
    vecs[1] = mk(1'b1, 1'b0, 32'd100,      32'd7,        32'd14,       4'b0000, 2'b00, 33);
    vecs[2] = mk(1'b1, 1'b0, 32'h1234,     32'd0,        32'hFFFFFFFF, 4'b1001, 2'b00, 1);
    vecs[3] = mk(1'b0, 1'b1, 32'h00010000, 32'h00010000, 32'd0,        4'b0100, 2'b11, 33);
    vecs[4] = mk(1'b1, 1'b1, 32'hFFFFFFFF, 32'h80000001, 32'd1,        4'b0000, 2'b11, 33);
    vecs[5] = mk(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        4'b0000, 2'b11, 33);
    vecs[6] = mk(1'b0, 1'b1, 32'h80000000, 32'd1,        32'h80000000, 4'b1000, 2'b11, 33);
    vecs[7] = mk(1'b1, 1'b1, 32'd7,        32'd100,      32'd0,        4'b0100, 2'b11, 33);
    vecs[8] = mk(1'b1, 1'b1, 32'd0,        32'd0,        32'hFFFFFFFF, 4'b1001, 2'b11, 1);

    bus.start     = 1'b0;
    bus.op        = 1'b0;
    bus.set_flags = 1'b0;
    bus.src_a     = '0;
    bus.src_b     = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_stall", bus.stall, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_flags", bus.flags_out, 0);
    check("rst_flag_w", bus.flag_w, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_op(vecs[i], 0);

    // Reset in cycle 10 of a MUL aborts it without a done pulse
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.set_flags = 1'b1;
    bus.src_a = 32'd123; bus.src_b = 32'd456;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_stall", bus.stall, 0);
    check("abort_done", bus.done, 0);
    check("abort_result", bus.result, 0);
    check("abort_flags", bus.flags_out, 0);
    check("abort_flag_w", bus.flag_w, 0);
    quiet("abort_no_done", 40);
    run_op(mk(1'b0, 1'b1, 32'd3, 32'd5, 32'd15, 4'b0000, 2'b11, 33), 0);

    // start and operand changes during CALC are ignored
    run_op(mk(1'b1, 1'b0, 32'd50, 32'd5, 32'd10, 4'b0000, 2'b00, 33), 5);
    quiet("poke_single_done", 40);

    // rst and start together: rst wins
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.op = 1'b0;
    bus.src_a = 32'd5; bus.src_b = 32'd5;
    #1 check("clash_stall", bus.stall, 0);
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    #1 check("clash_idle_stall", bus.stall, 0);
    quiet("clash_no_done", 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
